arp_tx: RTL and testbench
=========================

Name: arp_tx

Overview:
Transmit-side counterpart to the ARP receive path. Accepts a one-cycle command (request or reply, target MAC/IP, destination port) and emits one complete, padded 60-byte Ethernet/ARP frame on a 256-bit AXI4-Stream master. Sits beside the ingress ARP handling in netapp and feeds the egress output arbiter.

Parameters:
C_M_AXIS_DATA_WIDTH, 256, stream data width; only 256 is supported.
C_M_AXIS_TUSER_WIDTH, 128, tuser width.
C_SRC_PORT, 8'h00, value driven on tuser[23:16].

Ports:
axis_aclk  in  1  clock
axis_resetn  in  1  asynchronous active-low reset
local_mac  in  48  own MAC; sampled at command accept
local_ip  in  32  own IPv4 address; sampled at command accept
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_is_reply  in  1  0 = ARP request (oper 1); 1 = ARP reply (oper 2)
cmd_tha  in  48  target MAC; used only for replies
cmd_tpa  in  32  target IPv4 address
cmd_dst_port  in  8  one-hot NetFPGA port mask; driven on tuser[31:24]
m_axis_tdata  out  256  frame data
m_axis_tkeep  out  32  byte enables
m_axis_tuser  out  128  metadata
m_axis_tvalid  out  1  beat valid
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  last beat

Behaviour:
- Reset: state IDLE, cmd_ready=1, m_axis_tvalid=0, tlast=0, tdata/tkeep/tuser=0, all latched fields=0.
- FSM states: IDLE, BEAT0, BEAT1.
- IDLE: cmd_ready=1. On cmd_valid, latch all command fields plus local_mac and local_ip, then go to BEAT0. The first beat is valid on the next cycle (1-cycle latency).
- BEAT0: cmd_ready=0, tvalid=1, tkeep=32'hFFFFFFFF, tlast=0. Stays in BEAT0 until tready=1, then goes to BEAT1.
- BEAT1: tvalid=1, tkeep=32'h0FFFFFFF, tlast=1. Stays until tready=1, then goes to IDLE.
- No back-to-back frames: cmd_ready is re-asserted in the cycle after the BEAT1 handshake.
- AXIS rule: while tvalid=1 and tready=0, tdata, tkeep, tuser and tlast are held stable. tvalid never drops before its handshake.
- Byte order: frame byte i maps to tdata[8*(i%32)+7 : 8*(i%32)] of beat i/32. Multi-byte fields are big-endian on the wire, so the MSB goes in the lowest byte index.
- Beat 0 layout:
  - bytes 0-5: dst MAC. FF:FF:FF:FF:FF:FF for a request, cmd_tha for a reply.
  - bytes 6-11: local_mac. Bytes 12-13: 08 06.
  - bytes 14-15: 00 01. Bytes 16-17: 08 00. Byte 18: 06. Byte 19: 04.
  - bytes 20-21: oper, 00 01 (request) or 00 02 (reply).
  - bytes 22-27: sha = local_mac. Bytes 28-31: spa = local_ip.
- Beat 1 layout:
  - bytes 32-37: tha, all zeros for a request, cmd_tha for a reply.
  - bytes 38-41: tpa = cmd_tpa.
  - bytes 42-59: zero pad.
  - byte lanes 28-31 of beat 1 are driven 0.
- tuser on both beats: [15:0]=16'd60, [23:16]=C_SRC_PORT, [31:24]=cmd_dst_port, all other bits 0.
- local_mac or local_ip changing mid-frame has no effect; the latched values are used.
- Asynchronous reset mid-frame returns to IDLE immediately and drops tvalid. The truncated frame is not resumed.

Optional Feature:
Macro ARP_TX_STATS_EN.
- Defined: adds outputs stat_req_cnt[31:0] and stat_rep_cnt[31:0], both reset to 0.
  - The matching counter increments by 1 on the BEAT1 handshake (tvalid & tready & tlast).
  - Counters wrap from FFFFFFFF to 0.
  - Reset mid-frame does not count the frame.
- Undefined: the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Request accept: local_mac=02:11:22:33:44:55, local_ip=10.0.0.1, cmd_is_reply=0, cmd_tpa=10.0.0.2, cmd_dst_port=8'h01, tready=1.
  - Response: tvalid rises 1 cycle after accept. Beat0 bytes 0-5 = FF, bytes 20-21 = 00 01.
  - Beat1 bytes 32-37 = 0, bytes 38-41 = 0A 00 00 02, tkeep=0FFFFFFF, tlast=1.
  - tuser[15:0]=60, tuser[31:24]=01.
- Reply: cmd_is_reply=1, cmd_tha=AA:BB:CC:DD:EE:FF.
  - Response: dst MAC and tha both = AA:BB:CC:DD:EE:FF, oper = 00 02.
- Backpressure: tready=0 for 5 cycles on BEAT0, then 3 cycles on BEAT1.
  - Response: all outputs stable while stalled, exactly 2 handshakes, cmd_ready=0 throughout.
- Command during busy: cmd_valid held high from the accept onwards.
  - Response: second accept occurs only on the cycle after the BEAT1 handshake, and no beats are lost or merged.
- Reset mid-frame: assert axis_resetn=0 while stalled in BEAT1.
  - Response: tvalid=0 asynchronously and cmd_ready=1 after release.
  - With ARP_TX_STATS_EN defined, counts are unchanged at 0.
- Stats (ARP_TX_STATS_EN defined): send 3 requests and 2 replies.
  - Response: stat_req_cnt=3, stat_rep_cnt=2.

Source files
------------

// File: rtl/arp_tx.sv
// ARP frame transmitter: turns a one-cycle request/reply command into a padded 60-byte frame on a 256-bit AXI4-Stream.
// Optional per-opcode frame counters are enabled by defining ARP_TX_STATS_EN.
module arp_tx #(
    parameter int          C_M_AXIS_DATA_WIDTH  = 256,
    parameter int          C_M_AXIS_TUSER_WIDTH = 128,
    parameter logic [7:0]  C_SRC_PORT           = 8'h00
) (
    input  logic                                axis_aclk,
    input  logic                                axis_resetn,
    input  logic [47:0]                         local_mac,
    input  logic [31:0]                         local_ip,
    input  logic                                cmd_valid,
    output logic                                cmd_ready,
    input  logic                                cmd_is_reply,
    input  logic [47:0]                         cmd_tha,
    input  logic [31:0]                         cmd_tpa,
    input  logic [7:0]                          cmd_dst_port,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
    output logic                                m_axis_tlast
`ifdef ARP_TX_STATS_EN
    ,
    output logic [31:0]                         stat_req_cnt,
    output logic [31:0]                         stat_rep_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

    state_t      state_reg, state_next;
    logic        is_reply_reg;
    logic [47:0] tha_reg, mac_reg;
    logic [31:0] tpa_reg, ip_reg;
    logic [7:0]  dst_port_reg;

    logic [7:0]   frame_bytes [0:63];
    logic [511:0] frame_flat;
    logic [47:0]  dst_mac, tha_field;

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) state_reg <= IDLE;
        else              state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (cmd_valid)     state_next = BEAT0;
            BEAT0:   if (m_axis_tready) state_next = BEAT1;
            BEAT1:   if (m_axis_tready) state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    // Everything the frame needs is captured at accept so later input changes cannot leak in mid-frame.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            is_reply_reg <= 1'b0;
            tha_reg      <= '0;
            tpa_reg      <= '0;
            dst_port_reg <= '0;
            mac_reg      <= '0;
            ip_reg       <= '0;
        end else if (state_reg == IDLE && cmd_valid) begin
            is_reply_reg <= cmd_is_reply;
            tha_reg      <= cmd_tha;
            tpa_reg      <= cmd_tpa;
            dst_port_reg <= cmd_dst_port;
            mac_reg      <= local_mac;
            ip_reg       <= local_ip;
        end
    end

    assign dst_mac   = is_reply_reg ? tha_reg : 48'hFFFF_FFFF_FFFF;
    assign tha_field = is_reply_reg ? tha_reg : 48'h0;

    always_comb begin
        for (int k = 0; k < 64; k++) frame_bytes[k] = 8'h00;
        for (int k = 0; k < 6; k++) begin
            frame_bytes[k]      = dst_mac[47-8*k -: 8];
            frame_bytes[6+k]    = mac_reg[47-8*k -: 8];
            frame_bytes[22+k]   = mac_reg[47-8*k -: 8];
            frame_bytes[32+k]   = tha_field[47-8*k -: 8];
        end
        for (int k = 0; k < 4; k++) begin
            frame_bytes[28+k]   = ip_reg[31-8*k -: 8];
            frame_bytes[38+k]   = tpa_reg[31-8*k -: 8];
        end
        frame_bytes[12] = 8'h08;
        frame_bytes[13] = 8'h06;
        frame_bytes[15] = 8'h01;
        frame_bytes[16] = 8'h08;
        frame_bytes[18] = 8'h06;
        frame_bytes[19] = 8'h04;
        frame_bytes[21] = is_reply_reg ? 8'h02 : 8'h01;
    end

    // Frame byte i lands in lane i%32 of beat i/32.
    generate
        for (genvar gi = 0; gi < 64; gi++) begin : g_pack
            assign frame_flat[8*gi +: 8] = frame_bytes[gi];
        end
    endgenerate

    always_comb begin
        cmd_ready     = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tuser  = '0;
        case (state_reg)
            IDLE: cmd_ready = 1'b1;
            BEAT0: begin
                m_axis_tvalid       = 1'b1;
                m_axis_tdata        = frame_flat[255:0];
                m_axis_tkeep        = '1;
                m_axis_tuser[31:0]  = {dst_port_reg, C_SRC_PORT, 16'd60};
            end
            BEAT1: begin
                m_axis_tvalid       = 1'b1;
                m_axis_tlast        = 1'b1;
                m_axis_tdata        = frame_flat[511:256];
                m_axis_tkeep        = 32'h0FFF_FFFF;
                m_axis_tuser[31:0]  = {dst_port_reg, C_SRC_PORT, 16'd60};
            end
            default: cmd_ready = 1'b0;
        endcase
    end

`ifdef ARP_TX_STATS_EN
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            stat_req_cnt <= '0;
            stat_rep_cnt <= '0;
        end else if (state_reg == BEAT1 && m_axis_tready) begin
            if (is_reply_reg) stat_rep_cnt <= stat_rep_cnt + 32'd1;
            else              stat_req_cnt <= stat_req_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_arp_tx.sv
// Self-checking bench for arp_tx: directed and randomized frames compared against a byte-level frame model.
module tb_arp_tx;

    localparam logic [7:0] SRC_PORT = 8'h00;

    logic         axis_aclk = 1'b0;
    logic         axis_resetn;
    logic [47:0]  local_mac;
    logic [31:0]  local_ip;
    logic         cmd_valid;
    logic         cmd_ready;
    logic         cmd_is_reply;
    logic [47:0]  cmd_tha;
    logic [31:0]  cmd_tpa;
    logic [7:0]   cmd_dst_port;
    logic [255:0] m_axis_tdata;
    logic [31:0]  m_axis_tkeep;
    logic [127:0] m_axis_tuser;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         m_axis_tlast;
`ifdef ARP_TX_STATS_EN
    logic [31:0]  stat_req_cnt, stat_rep_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;
    int exp_req = 0;
    int exp_rep = 0;
    int frame_no = 0;

    always #5 axis_aclk = ~axis_aclk;

    arp_tx #(
        .C_M_AXIS_DATA_WIDTH (256),
        .C_M_AXIS_TUSER_WIDTH(128),
        .C_SRC_PORT          (SRC_PORT)
    ) dut (
        .axis_aclk    (axis_aclk),
        .axis_resetn  (axis_resetn),
        .local_mac    (local_mac),
        .local_ip     (local_ip),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_is_reply (cmd_is_reply),
        .cmd_tha      (cmd_tha),
        .cmd_tpa      (cmd_tpa),
        .cmd_dst_port (cmd_dst_port),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast)
`ifdef ARP_TX_STATS_EN
        ,
        .stat_req_cnt (stat_req_cnt),
        .stat_rep_cnt (stat_rep_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Frame as the wire sees it: an ordered byte list, padded to 64 and split into two 32-byte beats.
    task automatic build_frame(input bit rep, input logic [47:0] tha, input logic [31:0] tpa,
                               input logic [47:0] mac, input logic [31:0] ip,
                               output logic [255:0] b0, output logic [255:0] b1);
        logic [7:0]  q[$];
        logic [47:0] dst;
        logic [47:0] tfield;
        dst    = rep ? tha : 48'hFFFF_FFFF_FFFF;
        tfield = rep ? tha : 48'h0;
        for (int k = 5; k >= 0; k--) q.push_back(dst[8*k +: 8]);
        for (int k = 5; k >= 0; k--) q.push_back(mac[8*k +: 8]);
        q.push_back(8'h08); q.push_back(8'h06);
        q.push_back(8'h00); q.push_back(8'h01);
        q.push_back(8'h08); q.push_back(8'h00);
        q.push_back(8'h06); q.push_back(8'h04);
        q.push_back(8'h00); q.push_back(rep ? 8'h02 : 8'h01);
        for (int k = 5; k >= 0; k--) q.push_back(mac[8*k +: 8]);
        for (int k = 3; k >= 0; k--) q.push_back(ip[8*k +: 8]);
        for (int k = 5; k >= 0; k--) q.push_back(tfield[8*k +: 8]);
        for (int k = 3; k >= 0; k--) q.push_back(tpa[8*k +: 8]);
        while (q.size() < 64) q.push_back(8'h00);
        b0 = '0;
        b1 = '0;
        for (int i = 0; i < 32; i++) begin
            b0[8*i +: 8] = q[i];
            b1[8*i +: 8] = q[32+i];
        end
    endtask

    task automatic check_beat(input string tag, input logic [255:0] d, input logic [31:0] k,
                              input logic [127:0] u, input logic last);
        chk({tag, "_tvalid"}, m_axis_tvalid, 1'b1);
        chk({tag, "_tdata"}, m_axis_tdata, d);
        chk({tag, "_tkeep"}, m_axis_tkeep, k);
        chk({tag, "_tuser"}, m_axis_tuser, u);
        chk({tag, "_tlast"}, m_axis_tlast, last);
        chk({tag, "_cmd_ready"}, cmd_ready, 1'b0);
    endtask

    // Called #1 after a clock edge with the DUT idle; returns #1 after the edge following the last handshake.
    task automatic send_frame(input bit rep, input logic [47:0] tha, input logic [31:0] tpa,
                              input logic [7:0] port, input int st0, input int st1, input bit hold);
        logic [255:0] e0, e1;
        logic [127:0] eu;
        build_frame(rep, tha, tpa, local_mac, local_ip, e0, e1);
        eu = {96'h0, port, SRC_PORT, 16'd60};
        chk("idle_cmd_ready", cmd_ready, 1'b1);
        chk("idle_tvalid", m_axis_tvalid, 1'b0);
        cmd_valid    = 1'b1;
        cmd_is_reply = rep;
        cmd_tha      = tha;
        cmd_tpa      = tpa;
        cmd_dst_port = port;
        @(posedge axis_aclk); #1;
        if (!hold) begin
            cmd_valid    = 1'b0;
            cmd_is_reply = ~rep;
            cmd_tha      = 48'({$urandom(), $urandom()});
            cmd_tpa      = $urandom();
            cmd_dst_port = 8'($urandom());
        end
        local_mac = 48'({$urandom(), $urandom()});
        local_ip  = $urandom();
        for (int c = 0; c <= st0; c++) begin
            m_axis_tready = (c == st0);
            check_beat("beat0", e0, 32'hFFFF_FFFF, eu, 1'b0);
            @(posedge axis_aclk); #1;
        end
        for (int c = 0; c <= st1; c++) begin
            m_axis_tready = (c == st1);
            check_beat("beat1", e1, 32'h0FFF_FFFF, eu, 1'b1);
            @(posedge axis_aclk); #1;
        end
        if (rep) exp_rep++;
        else     exp_req++;
        frame_no++;
        chk("post_tvalid", m_axis_tvalid, 1'b0);
        chk("post_cmd_ready", cmd_ready, 1'b1);
        $display("frame %0d: %s tpa=%h port=%h stalls=%0d/%0d", frame_no, rep ? "reply" : "request",
                 tpa, port, st0, st1);
    endtask

    initial begin
        axis_resetn   = 1'b0;
        local_mac     = 48'h02_11_22_33_44_55;
        local_ip      = 32'h0A_00_00_01;
        cmd_valid     = 1'b0;
        cmd_is_reply  = 1'b0;
        cmd_tha       = '0;
        cmd_tpa       = '0;
        cmd_dst_port  = '0;
        m_axis_tready = 1'b1;

        @(posedge axis_aclk); #1;
        @(posedge axis_aclk); #1;
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_tlast", m_axis_tlast, 1'b0);
        chk("rst_tdata", m_axis_tdata, 256'h0);
        chk("rst_tkeep", m_axis_tkeep, 32'h0);
        chk("rst_tuser", m_axis_tuser, 128'h0);
`ifdef ARP_TX_STATS_EN
        chk("rst_req_cnt", stat_req_cnt, 32'd0);
        chk("rst_rep_cnt", stat_rep_cnt, 32'd0);
`endif
        axis_resetn = 1'b1;
        @(posedge axis_aclk); #1;

        // Directed request and reply.
        local_mac = 48'h02_11_22_33_44_55;
        local_ip  = 32'h0A_00_00_01;
        send_frame(1'b0, 48'h0, 32'h0A_00_00_02, 8'h01, 0, 0, 1'b0);
        local_mac = 48'h02_11_22_33_44_55;
        local_ip  = 32'h0A_00_00_01;
        send_frame(1'b1, 48'hAA_BB_CC_DD_EE_FF, 32'h0A_00_00_02, 8'h04, 0, 0, 1'b0);

        // Backpressure on both beats.
        send_frame(1'b0, 48'h12_34_56_78_9A_BC, 32'hC0_A8_01_07, 8'h10, 5, 3, 1'b0);

        // Command held valid while busy: next accept only after the last handshake.
        send_frame(1'b1, 48'h01_02_03_04_05_06, 32'hC0_A8_00_09, 8'h02, 1, 2, 1'b1);
        send_frame(1'b1, 48'h01_02_03_04_05_06, 32'hC0_A8_00_09, 8'h02, 0, 0, 1'b0);

        // Randomized frames.
        for (int n = 0; n < 20; n++) begin
            send_frame(1'($urandom()), 48'({$urandom(), $urandom()}), $urandom(),
                       8'(1 << $urandom_range(0, 7)), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
        end

        // Reset while stalled in the last beat; the frame must be dropped and not counted.
        cmd_valid     = 1'b1;
        cmd_is_reply  = 1'b0;
        cmd_tpa       = 32'h0A_00_00_63;
        cmd_dst_port  = 8'h08;
        m_axis_tready = 1'b1;
        @(posedge axis_aclk); #1;
        cmd_valid = 1'b0;
        @(posedge axis_aclk); #1;
        m_axis_tready = 1'b0;
        chk("midrst_in_beat1_tlast", m_axis_tlast, 1'b1);
        @(posedge axis_aclk); #1;
        axis_resetn = 1'b0;
        #1;
        chk("midrst_async_tvalid", m_axis_tvalid, 1'b0);
        chk("midrst_async_tlast", m_axis_tlast, 1'b0);
        @(posedge axis_aclk); #1;
        axis_resetn   = 1'b1;
        m_axis_tready = 1'b1;
        @(posedge axis_aclk); #1;
        chk("midrst_cmd_ready", cmd_ready, 1'b1);
        chk("midrst_tvalid", m_axis_tvalid, 1'b0);
        $display("frame aborted by reset");
`ifdef ARP_TX_STATS_EN
        chk("midrst_req_cnt", stat_req_cnt, 32'd0);
        chk("midrst_rep_cnt", stat_rep_cnt, 32'd0);
        exp_req = 0;
        exp_rep = 0;
        for (int n = 0; n < 5; n++) begin
            send_frame(n >= 3, 48'({$urandom(), $urandom()}), $urandom(), 8'h01, 0, n % 2, 1'b0);
        end
        chk("stats_req_cnt", stat_req_cnt, 32'(exp_req));
        chk("stats_rep_cnt", stat_rep_cnt, 32'(exp_rep));
`else
        send_frame(1'b0, 48'h0, 32'h0A_00_00_05, 8'h01, 0, 0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
